stage_mem: RTL and testbench

- Memory-access stage of the 5-stage pipeline, sitting between the EX/MEM latch and the write-back stage.
- Issues data-memory read/write requests to the dcache using the REN/WEN/dhit handshake.
- Holds the request and asserts a stall until dhit arrives.
- Contains the MEM/WB pipeline register that feeds the write-back stage inputs (memtoReg, jal, regWrite, regSel, dmemload, aluOut, npc).

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/stage_mem_if.sv | 22 ++
 rtl/memwb_reg.sv | 21 ++
 rtl/stage_mem.sv | 112 +++++++++++
 tb/tb_stage_mem.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word type, MEM-stage FSM states and the MEM/WB latch layout.
package cpu_types_pkg;

  localparam int unsigned WordW = 32;

  typedef logic [WordW-1:0] word_t;
  typedef logic [4:0]       regbits_t;

  typedef enum logic {IDLE, WAIT} mem_state_t;

  typedef struct packed {
    logic     memtoReg;
    logic     jal;
    logic     regWrite;
    regbits_t regSel;
    word_t    dmemload;
    word_t    aluOut;
    word_t    npc;
  } memwb_t;

endpackage

// File: rtl/stage_mem_if.sv
// Data-cache request/response bundle between the MEM stage and the dcache.
interface stage_mem_if;
  import cpu_types_pkg::*;

  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  dhit;
  word_t dmemload;

  modport mem (
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  dhit, dmemload
  );

  modport cache (
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    output dhit, dmemload
  );

endinterface

// File: rtl/memwb_reg.sv
// Pipeline latch of memwb_t with hold (en=0) and bubble insertion; bubbles clear every field.
module memwb_reg
  import cpu_types_pkg::*;
(
  input  logic   CLK,
  input  logic   RST,
  input  logic   en,
  input  logic   bubble,
  input  memwb_t d,
  output memwb_t q
);

  always_ff @(posedge CLK) begin
    if (RST) begin
      q <= '0;
    end else if (en) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/stage_mem.sv
// Memory-access stage: drives dcache requests, stalls upstream until dhit, and owns the MEM/WB latch.
module stage_mem
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned WORD_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              valid_in,
  input  logic              memRead_in,
  input  logic              memWrite_in,
  input  logic              memtoReg_in,
  input  logic              jal_in,
  input  logic              regWrite_in,
  input  logic [4:0]        regSel_in,
  input  logic [WORD_W-1:0] aluOut_in,
  input  logic [WORD_W-1:0] storeData_in,
  input  logic [WORD_W-1:0] npc_in,
  input  logic              halt_in,
  input  logic              flush,
  stage_mem_if.mem          dcache,
  output logic              mem_stall,
  output logic              memtoReg_out,
  output logic              jal_out,
  output logic              regWrite_out,
  output logic [4:0]        regSel_out,
  output logic [WORD_W-1:0] dmemload_out,
  output logic [WORD_W-1:0] aluOut_out,
  output logic [WORD_W-1:0] npc_out,
  output logic              halt_out,
  output logic [CNT_W-1:0]  stall_cycles
);

  mem_state_t       state_q, state_d;
  logic             halt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req;
  logic             accept;
  memwb_t           wb_d, wb_q;

  // Reset gates the request so a held miss drops during the reset cycle.
  always_comb begin
    dcache.dmemREN   = valid_in & memRead_in & ~halt_q & ~RST;
    dcache.dmemWEN   = valid_in & memWrite_in & ~memRead_in & ~halt_q & ~RST;
    dcache.dmemaddr  = aluOut_in;
    dcache.dmemstore = storeData_in;
    req              = dcache.dmemREN | dcache.dmemWEN;
    mem_stall        = req & ~dcache.dhit;
    accept           = ~mem_stall & ~flush & valid_in;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req && !dcache.dhit) state_d = WAIT;
      WAIT: if (dcache.dhit)         state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    wb_d          = '0;
    wb_d.memtoReg = memtoReg_in;
    wb_d.jal      = jal_in;
    wb_d.regWrite = regWrite_in;
    wb_d.regSel   = regSel_in;
    wb_d.dmemload = memRead_in ? dcache.dmemload : '0;
    wb_d.aluOut   = aluOut_in;
    wb_d.npc      = npc_in;
  end

  memwb_reg u_memwb (
    .CLK    (CLK),
    .RST    (RST),
    .en     (1'b1),
    .bubble (~accept),
    .d      (wb_d),
    .q      (wb_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_q | (accept & halt_in);
      if (mem_stall && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  // Hazard unit never flushes a stalled access; a held request never vanishes mid-wait.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      assert (!(flush && mem_stall));
      assert (state_q != WAIT || req);
    end
  end

  assign memtoReg_out = wb_q.memtoReg;
  assign jal_out      = wb_q.jal;
  assign regWrite_out = wb_q.regWrite;
  assign regSel_out   = wb_q.regSel;
  assign dmemload_out = wb_q.dmemload;
  assign aluOut_out   = wb_q.aluOut;
  assign npc_out      = wb_q.npc;
  assign halt_out     = halt_q;
  assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: default instance plus a CNT_W=4 instance for counter saturation.
module tb_stage_mem;
  import cpu_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in, memRead_in, memWrite_in, memtoReg_in, jal_in, regWrite_in;
  logic [4:0]  regSel_in;
  logic [31:0] aluOut_in, storeData_in, npc_in;
  logic        halt_in, flush;

  logic        mem_stall, memtoReg_out, jal_out, regWrite_out, halt_out;
  logic [4:0]  regSel_out;
  logic [31:0] dmemload_out, aluOut_out, npc_out;
  logic [15:0] stall_cycles;

  logic        mem_stall4, memtoReg_out4, jal_out4, regWrite_out4, halt_out4;
  logic [4:0]  regSel_out4;
  logic [31:0] dmemload_out4, aluOut_out4, npc_out4;
  logic [3:0]  stall_cycles4;

  int checks = 0;
  int errors = 0;

  stage_mem_if mif ();
  stage_mem_if mif4 ();

  always #5 clk = ~clk;

  stage_mem dut (
    .CLK(clk), .RST(rst), .valid_in(valid_in), .memRead_in(memRead_in),
    .memWrite_in(memWrite_in), .memtoReg_in(memtoReg_in), .jal_in(jal_in),
    .regWrite_in(regWrite_in), .regSel_in(regSel_in), .aluOut_in(aluOut_in),
    .storeData_in(storeData_in), .npc_in(npc_in), .halt_in(halt_in), .flush(flush),
    .dcache(mif.mem), .mem_stall(mem_stall), .memtoReg_out(memtoReg_out), .jal_out(jal_out),
    .regWrite_out(regWrite_out), .regSel_out(regSel_out), .dmemload_out(dmemload_out),
    .aluOut_out(aluOut_out), .npc_out(npc_out), .halt_out(halt_out),
    .stall_cycles(stall_cycles)
  );

  stage_mem #(.CNT_W(4)) dut4 (
    .CLK(clk), .RST(rst), .valid_in(valid_in), .memRead_in(memRead_in),
    .memWrite_in(memWrite_in), .memtoReg_in(memtoReg_in), .jal_in(jal_in),
    .regWrite_in(regWrite_in), .regSel_in(regSel_in), .aluOut_in(aluOut_in),
    .storeData_in(storeData_in), .npc_in(npc_in), .halt_in(halt_in), .flush(flush),
    .dcache(mif4.mem), .mem_stall(mem_stall4), .memtoReg_out(memtoReg_out4),
    .jal_out(jal_out4), .regWrite_out(regWrite_out4), .regSel_out(regSel_out4),
    .dmemload_out(dmemload_out4), .aluOut_out(aluOut_out4), .npc_out(npc_out4),
    .halt_out(halt_out4), .stall_cycles(stall_cycles4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid_in = 0; memRead_in = 0; memWrite_in = 0; memtoReg_in = 0; jal_in = 0;
    regWrite_in = 0; regSel_in = 0; aluOut_in = 0; storeData_in = 0; npc_in = 0;
    halt_in = 0; flush = 0;
    mif.dhit = 0; mif.dmemload = 0; mif4.dhit = 1; mif4.dmemload = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({regWrite_out, memtoReg_out, jal_out, halt_out, regSel_out} !== 9'd0 ||
        {dmemload_out, aluOut_out, npc_out} !== 96'd0) begin
      errors++;
      $display("FAIL reset_wb: got rw=%b rs=%0d ld=%h alu=%h npc=%h want all 0",
               regWrite_out, regSel_out, dmemload_out, aluOut_out, npc_out);
    end
    checks++;
    if (stall_cycles !== 16'd0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d st=%0d want 0/IDLE", stall_cycles, dut.state_q);
    end
    checks++;
    if ({mif.dmemREN, mif.dmemWEN, mem_stall} !== 3'b000) begin
      errors++;
      $display("FAIL reset_req: got %b want 000", {mif.dmemREN, mif.dmemWEN, mem_stall});
    end
  endtask

  task automatic test_load_hit();
    valid_in = 1; memRead_in = 1; memtoReg_in = 1; regWrite_in = 1; regSel_in = 5;
    aluOut_in = 32'h100; npc_in = 32'h44; mif.dhit = 1; mif.dmemload = 32'hDEADBEEF;
    #1;
    checks++;
    if ({mif.dmemREN, mif.dmemWEN, mem_stall} !== 3'b100 || mif.dmemaddr !== 32'h100) begin
      errors++;
      $display("FAIL load_req: got ren/wen/stall=%b addr=%h want 100 addr=00000100",
               {mif.dmemREN, mif.dmemWEN, mem_stall}, mif.dmemaddr);
    end
    tick();
    idle_inputs();
    checks++;
    if (dmemload_out !== 32'hDEADBEEF || regWrite_out !== 1'b1 || regSel_out !== 5'd5 ||
        memtoReg_out !== 1'b1 || npc_out !== 32'h44) begin
      errors++;
      $display("FAIL load_wb: got ld=%h rw=%b rs=%0d m2r=%b npc=%h want deadbeef 1 5 1 44",
               dmemload_out, regWrite_out, regSel_out, memtoReg_out, npc_out);
    end
    checks++;
    if (stall_cycles !== 16'd0 || dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL load_cnt: got cnt=%0d st=%0d want 0/IDLE", stall_cycles, dut.state_q);
    end
  endtask

  task automatic test_store_miss();
    valid_in = 1; memWrite_in = 1; aluOut_in = 32'h200; storeData_in = 32'h12345678;
    npc_in = 32'h80; regSel_in = 3;
    for (int i = 0; i < 4; i++) begin
      mif.dhit = (i == 3);
      #1;
      checks++;
      if (mif.dmemWEN !== 1'b1 || mif.dmemREN !== 1'b0 || mif.dmemaddr !== 32'h200 ||
          mif.dmemstore !== 32'h12345678 || mem_stall !== (i != 3)) begin
        errors++;
        $display("FAIL store_req[%0d]: got wen=%b ren=%b addr=%h data=%h stall=%b want 1 0 200 12345678 %b",
                 i, mif.dmemWEN, mif.dmemREN, mif.dmemaddr, mif.dmemstore, mem_stall, i != 3);
      end
      tick();
      if (i < 3) begin
        checks++;
        if (npc_out !== 32'd0 || regWrite_out !== 1'b0 || dut.state_q !== WAIT) begin
          errors++;
          $display("FAIL store_bubble[%0d]: got npc=%h rw=%b st=%0d want 0 0 WAIT",
                   i, npc_out, regWrite_out, dut.state_q);
        end
      end
    end
    idle_inputs();
    checks++;
    if (npc_out !== 32'h80 || regSel_out !== 5'd3 || dmemload_out !== 32'd0 ||
        dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL store_wb: got npc=%h rs=%0d ld=%h st=%0d want 80 3 0 IDLE",
               npc_out, regSel_out, dmemload_out, dut.state_q);
    end
    checks++;
    if (stall_cycles !== 16'd3) begin
      errors++;
      $display("FAIL store_cnt: got %0d want 3", stall_cycles);
    end
  endtask

  task automatic test_alu_flush();
    valid_in = 1; regWrite_in = 1; jal_in = 1; aluOut_in = 32'h2A; regSel_in = 7;
    tick();
    checks++;
    if (aluOut_out !== 32'h2A || regWrite_out !== 1'b1 || regSel_out !== 5'd7 ||
        jal_out !== 1'b1) begin
      errors++;
      $display("FAIL alu_wb: got alu=%h rw=%b rs=%0d jal=%b want 2a 1 7 1",
               aluOut_out, regWrite_out, regSel_out, jal_out);
    end
    aluOut_in = 32'h55; regSel_in = 9; flush = 1;
    tick();
    idle_inputs();
    checks++;
    if (regWrite_out !== 1'b0 || jal_out !== 1'b0 || aluOut_out !== 32'd0) begin
      errors++;
      $display("FAIL flush_wb: got rw=%b jal=%b alu=%h want 0 0 0",
               regWrite_out, jal_out, aluOut_out);
    end
  endtask

  task automatic test_halt();
    valid_in = 1; halt_in = 1;
    tick();
    idle_inputs();
    checks++;
    if (halt_out !== 1'b1) begin
      errors++;
      $display("FAIL halt_set: got %b want 1", halt_out);
    end
    tick();
    valid_in = 1; memRead_in = 1; aluOut_in = 32'h300;
    #1;
    checks++;
    if (halt_out !== 1'b1 || mif.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL halt_block: got halt=%b ren=%b stall=%b want 1 0 0",
               halt_out, mif.dmemREN, mem_stall);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_rst_wait();
    do_reset();
    valid_in = 1; memRead_in = 1; regWrite_in = 1; regSel_in = 4; aluOut_in = 32'h400;
    tick();
    tick();
    checks++;
    if (dut.state_q !== WAIT || stall_cycles !== 16'd2 || mem_stall !== 1'b1) begin
      errors++;
      $display("FAIL rstw_pre: got st=%0d cnt=%0d stall=%b want WAIT 2 1",
               dut.state_q, stall_cycles, mem_stall);
    end
    rst = 1;
    #1;
    checks++;
    if (mif.dmemREN !== 1'b0) begin
      errors++;
      $display("FAIL rstw_gate: got ren=%b want 0", mif.dmemREN);
    end
    tick();
    rst = 0;
    idle_inputs();
    #1;
    checks++;
    if (dut.state_q !== IDLE || stall_cycles !== 16'd0 || regWrite_out !== 1'b0 ||
        regSel_out !== 5'd0 || halt_out !== 1'b0 || mif.dmemREN !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL rstw_post: got st=%0d cnt=%0d rw=%b rs=%0d halt=%b ren=%b stall=%b want all 0",
               dut.state_q, stall_cycles, regWrite_out, regSel_out, halt_out, mif.dmemREN,
               mem_stall);
    end
  endtask

  task automatic test_saturate();
    valid_in = 1; memRead_in = 1; aluOut_in = 32'h500; mif.dhit = 1; mif4.dhit = 0;
    for (int i = 0; i < 14; i++) tick();
    checks++;
    if (stall_cycles4 !== 4'd14) begin
      errors++;
      $display("FAIL sat_mid: got %0d want 14", stall_cycles4);
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (stall_cycles4 !== 4'd15 || stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL sat_top: got cnt4=%0d cnt=%0d want 15 0", stall_cycles4, stall_cycles);
    end
    mif4.dhit = 1;
    tick();
    idle_inputs();
    tick();
    checks++;
    if (stall_cycles4 !== 4'd15 || dut4.state_q !== IDLE) begin
      errors++;
      $display("FAIL sat_hold: got cnt4=%0d st=%0d want 15 IDLE", stall_cycles4, dut4.state_q);
    end
  endtask

  initial begin
    test_reset();
    test_load_hit();
    test_store_miss();
    test_alu_flush();
    test_halt();
    test_rst_wait();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
